rgmii_tx_speed_adapter: RTL
===========================

RGMII_TX_SPEED_ADAPTER -- requirements
Module: rgmii_tx_speed_adapter

Interface
REQ-001 SHALL have parameter CLK_DIV_100, default 5: clk cycles per nibble at 100M, legal range 2..63.
REQ-002 SHALL have parameter CLK_DIV_10, default 50: clk cycles per nibble at 10M, legal range 2..63.
REQ-003 SHALL have port clk, input, 1: transmit clock (125 MHz); the block's only clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous to clk, active-high.
REQ-005 SHALL have port speed, input, 2: requested speed; 2'b10 and 2'b11 = 1G, 2'b01 = 100M, 2'b00 = 10M.
REQ-006 SHALL have ports gmii_txd (input, 8), gmii_tx_en (input, 1) and gmii_tx_er (input, 1): GMII byte from the MAC.
REQ-007 SHALL have port gmii_tx_clk_en, output, 1: byte strobe; the MAC presents the next byte in the cycle this is high.
REQ-008 SHALL have ports txc_d1 and txc_d2, output, 1 each: TXC values for the rising and falling halves of clk, driving the ODDR.
REQ-009 SHALL have ports txd_d1 and txd_d2, output, 4 each: TD values for the rising and falling halves of clk.
REQ-010 SHALL have ports tx_ctl_d1 and tx_ctl_d2, output, 1 each: TX_CTL values for the rising and falling halves of clk.
REQ-011 SHALL have port speed_active, output, 2: speed currently in effect.
REQ-012 SHALL have port tx_er_count, output, 16: errored-byte count, present only when the macro in REQ-026 is defined.

Function
REQ-013 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-014 SHALL, at 1G, hold gmii_tx_clk_en=1 constantly.
REQ-015 SHALL, at 1G, register on every cycle: txd_d1=txd[3:0], txd_d2=txd[7:4], tx_ctl_d1=en, tx_ctl_d2=en^er, txc_d1=1, txc_d2=0; latency 1 cycle.
REQ-016 SHALL, at 10M/100M, use nibble period N (CLK_DIV_10 or CLK_DIV_100), a cycle counter cnt (0..N-1) and a two-state phase FSM, LO -> HI -> LO.
REQ-017 SHALL assert gmii_tx_clk_en for exactly one cycle per byte, when phase=HI and cnt=N-1, and capture gmii_txd/en/er into a holding register on that edge.
REQ-018 SHALL drive txd_d1 = txd_d2 = held[3:0] during phase LO and held[7:4] during phase HI, each for N cycles, so a byte spans 2N cycles.
REQ-019 SHALL index half-cycles h = 2*cnt (d1) and 2*cnt+1 (d2) within each nibble.
REQ-020 SHALL drive TXC = 0 for h < N and 1 for h >= N (50% duty; odd N gives the rising edge mid-cycle).
REQ-021 SHALL drive TX_CTL = held_en for 1 <= h <= N and held_en^held_er otherwise.
REQ-022 SHALL sample speed only at a byte boundary (1G: every cycle; 10/100: the gmii_tx_clk_en cycle), load it into speed_active and reset cnt=0, phase=LO; a speed change mid-byte SHALL never truncate the byte.
REQ-023 SHALL present the first byte accepted after a change from 1G to 10/100 on the next cycle (LO nibble, cnt=0).
REQ-024 SHALL, when changing from 10/100 to 1G, make the first 1G byte the one presented in the final gmii_tx_clk_en cycle.

Reset
REQ-025 SHALL, while rst is high, force txc_d1=1, txc_d2=0, txd_d1/d2=0, tx_ctl_d1/d2=0, gmii_tx_clk_en=1, speed_active=2'b10, cnt=0, phase=LO, holding register=0 and tx_er_count=0; speed SHALL be sampled on the first cycle after rst falls (1G boundary); rst mid-byte SHALL discard the byte.

Configuration
REQ-026 SHALL, with RGMII_TX_ER_COUNT_EN defined, provide tx_er_count, incremented once per accepted byte with en=1 and er=1, saturating at 16'hFFFF; without the macro the port, counter and logic SHALL be absent.

Structure
REQ-027 SHALL place the speed encodings (SPEED_1G, SPEED_100M, SPEED_10M) and the phase enum in shared package rgmii_pkg.
REQ-028 SHALL implement the cnt/phase/TXC-pattern generator as sub-module rgmii_tx_clk_gen.
REQ-029 SHALL keep the data path in the top module; ODDR primitives SHALL live outside this block.

Verification
REQ-030 SHALL cover: 1G, txd=8'hA5, en=1, er=0 -> next cycle txd_d1=4'h5, txd_d2=4'hA, tx_ctl_d1=1, tx_ctl_d2=1, clk_en=1 continuously.
REQ-031 SHALL cover: 100M (N=5), byte 8'h3C, en=1 -> TD=4'hC for 5 cycles then 4'h3 for 5 cycles; clk_en pulses every 10 cycles; TXC d1/d2 per nibble = 00,00,01,11,11.
REQ-032 SHALL cover: 10M (N=50), en=1, er=1 -> TX_CTL=1 for h=1..50, 0 otherwise; clk_en period 100 cycles.
REQ-033 SHALL cover: speed switched 100M->1G at cycle 3 of an LO nibble -> the byte completes its full 10 cycles, then speed_active=2'b10 and clk_en stays 1.
REQ-034 SHALL cover: rst asserted mid-HI nibble at 10M -> next cycle all outputs at reset values; after release the speed is resampled and a fresh LO nibble starts.
REQ-035 SHALL cover: with RGMII_TX_ER_COUNT_EN, 3 bytes with en=er=1 and 1 byte with er=1, en=0 -> tx_er_count=3; preloaded 16'hFFFE plus 3 errored bytes -> 16'hFFFF.

Source files
------------

// File: rtl/rgmii_pkg.sv
// -----------------------------------------------------------------------------
// rgmii_pkg
// Shared definitions for the RGMII transmit speed adapter.
//   SPEED_1G / SPEED_100M / SPEED_10M : encodings of the 2-bit speed selector
//                                       (2'b11 also decodes as 1G)
//   phase_t                           : nibble phase of a 10/100 byte
//   is_gig()                          : 1G decode of a speed code
// -----------------------------------------------------------------------------
package rgmii_pkg;

  localparam logic [1:0] SPEED_1G   = 2'b10;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_10M  = 2'b00;

  // LO carries the low nibble of a held byte, HI the high nibble.
  typedef enum logic {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } phase_t;

  // Both 2'b10 and 2'b11 select gigabit operation.
  function automatic logic is_gig(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/rgmii_tx_speed_adapter_if.sv
// -----------------------------------------------------------------------------
// rgmii_tx_speed_adapter_if
// Bundles the GMII byte interface from the MAC and the per-half-cycle RGMII
// values handed to the external ODDR primitives.
//   gmii_txd[7:0], gmii_tx_en, gmii_tx_er : byte from the MAC
//   gmii_tx_clk_en                        : byte strobe back to the MAC
//   txc_d1/d2, txd_d1/d2[3:0], tx_ctl_d1/d2 : rising/falling-half values
// Modports:
//   master : MAC / pad side (drives the GMII byte, observes the rest)
//   slave  : the adapter
// -----------------------------------------------------------------------------
interface rgmii_tx_speed_adapter_if;

  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       gmii_tx_clk_en;

  logic       txc_d1;
  logic       txc_d2;
  logic [3:0] txd_d1;
  logic [3:0] txd_d2;
  logic       tx_ctl_d1;
  logic       tx_ctl_d2;

  modport master (
    output gmii_txd, gmii_tx_en, gmii_tx_er,
    input  gmii_tx_clk_en,
    input  txc_d1, txc_d2, txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2
  );

  modport slave (
    input  gmii_txd, gmii_tx_en, gmii_tx_er,
    output gmii_tx_clk_en,
    output txc_d1, txc_d2, txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2
  );

endinterface

// File: rtl/rgmii_tx_clk_gen.sv
// -----------------------------------------------------------------------------
// rgmii_tx_clk_gen
// Nibble timing generator for 10/100 operation: a cycle counter cnt (0..N-1)
// and a LO -> HI -> LO phase FSM. It produces the *next-cycle* values of the
// phase, the TXC pattern, the TX_CTL window and the byte strobe so that the
// top can register every output.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   gig                 : next cycle runs at 1G (counter parked at 0/LO)
//   restart             : byte boundary; next cycle starts a fresh LO nibble
//   n_div[5:0]          : nibble period N in clk cycles for the next cycle
//   phase_nxt           : phase of the next cycle
//   txc1_nxt, txc2_nxt  : TXC for the rising/falling half of the next cycle
//   win1_nxt, win2_nxt  : half-cycle lies in the TX_CTL = en window
//   strobe_nxt          : next cycle is the last of the byte (byte strobe)
// -----------------------------------------------------------------------------
module rgmii_tx_clk_gen
  import rgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       gig,
  input  logic       restart,
  input  logic [5:0] n_div,
  output phase_t     phase_nxt,
  output logic       txc1_nxt,
  output logic       txc2_nxt,
  output logic       win1_nxt,
  output logic       win2_nxt,
  output logic       strobe_nxt
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_nxt;
  phase_t     phase_q;
  logic [5:0] n_m1;
  logic [6:0] n_ext;
  logic [6:0] h1;
  logic [6:0] h2;

  assign n_m1  = n_div - 6'd1;
  assign n_ext = {1'b0, n_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PHASE_LO;
    end else begin
      cnt_q   <= cnt_nxt;
      phase_q <= phase_nxt;
    end
  end

  // Counter / phase next state. A boundary always restarts at LO, cnt 0; this
  // matters when leaving 1G, where the counter is parked at 0 and would
  // otherwise advance to 1 on the first 10/100 cycle.
  always_comb begin
    cnt_nxt   = cnt_q;
    phase_nxt = phase_q;
    if (gig || restart) begin
      cnt_nxt   = '0;
      phase_nxt = PHASE_LO;
    end else if (cnt_q == n_m1) begin
      cnt_nxt   = '0;
      phase_nxt = (phase_q == PHASE_LO) ? PHASE_HI : PHASE_LO;
    end else begin
      cnt_nxt   = cnt_q + 6'd1;
    end
  end

  // Half-cycle index within the nibble: h = 2*cnt (rising), 2*cnt+1 (falling).
  // TXC is low for the first N half-cycles and high for the last N, which
  // keeps 50% duty even for odd N (the edge then falls mid-cycle).
  always_comb begin
    h1         = {cnt_nxt, 1'b0};
    h2         = {cnt_nxt, 1'b1};
    txc1_nxt   = gig ? 1'b1 : (h1 >= n_ext);
    txc2_nxt   = gig ? 1'b0 : (h2 >= n_ext);
    win1_nxt   = (h1 != 7'd0) && (h1 <= n_ext);
    win2_nxt   = (h2 <= n_ext);
    strobe_nxt = gig ? 1'b1 : ((phase_nxt == PHASE_HI) && (cnt_nxt == n_m1));
  end

endmodule

// File: rtl/rgmii_tx_speed_adapter.sv
// -----------------------------------------------------------------------------
// rgmii_tx_speed_adapter
// Converts a GMII byte stream into RGMII per-half-cycle values (for external
// ODDRs) at 1G, 100M or 10M, all from the single 125 MHz transmit clock.
// At 1G a byte is taken every cycle; at 10/100 each byte is held for two
// nibble periods of N clk cycles, with a 50% duty TXC generated in the
// half-cycle domain. The speed selector is only honoured at a byte boundary
// so a byte is never cut short.
// Parameters:
//   CLK_DIV_100 : clk cycles per nibble at 100M (2..63)
//   CLK_DIV_10  : clk cycles per nibble at 10M  (2..63)
// Ports:
//   clk, rst     : 125 MHz clock, synchronous active-high reset
//   speed[1:0]   : requested speed (1x = 1G, 01 = 100M, 00 = 10M)
//   bus          : GMII input byte, byte strobe, RGMII d1/d2 outputs
//   speed_active : speed currently in effect
//   tx_er_count  : saturating count of bytes sent with en=1, er=1
//                  (only with RGMII_TX_ER_COUNT_EN defined)
// Build option:
//   RGMII_TX_ER_COUNT_EN : adds the tx_er_count port and counter.
// All outputs are registered.
// -----------------------------------------------------------------------------
module rgmii_tx_speed_adapter
  import rgmii_pkg::*;
#(
  parameter int CLK_DIV_100 = 5,
  parameter int CLK_DIV_10  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  speed,
  rgmii_tx_speed_adapter_if.slave bus,
  output logic [1:0]  speed_active
`ifdef RGMII_TX_ER_COUNT_EN
  ,
  output logic [15:0] tx_er_count
`endif
);

  logic       boundary;
  logic [1:0] speed_nxt;
  logic       gig_nxt;
  logic [5:0] n_div;

  logic [7:0] held_byte_p0;
  logic       held_en_p0;
  logic       held_er_p0;
  logic [7:0] held_byte_nxt;
  logic       held_en_nxt;
  logic       held_er_nxt;

  phase_t     phase_nxt;
  logic       txc1_nxt;
  logic       txc2_nxt;
  logic       win1_nxt;
  logic       win2_nxt;
  logic       strobe_nxt;

  logic [3:0] nib_nxt;
  logic [3:0] td1_nxt;
  logic [3:0] td2_nxt;
  logic       ctl1_nxt;
  logic       ctl2_nxt;

  // The registered strobe marks the cycle in which the MAC's byte is taken.
  // It is held high at 1G and in reset, so the speed is resampled every
  // cycle at 1G and on the first cycle after reset.
  assign boundary = bus.gmii_tx_clk_en;

  // Byte capture and speed sampling happen only at the boundary.
  always_comb begin
    speed_nxt     = speed_active;
    held_byte_nxt = held_byte_p0;
    held_en_nxt   = held_en_p0;
    held_er_nxt   = held_er_p0;
    if (boundary) begin
      speed_nxt     = speed;
      held_byte_nxt = bus.gmii_txd;
      held_en_nxt   = bus.gmii_tx_en;
      held_er_nxt   = bus.gmii_tx_er;
    end
  end

  assign gig_nxt = is_gig(speed_nxt);
  assign n_div   = (speed_nxt == SPEED_100M) ? 6'(CLK_DIV_100) : 6'(CLK_DIV_10);

  rgmii_tx_clk_gen u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .gig        (gig_nxt),
    .restart    (boundary),
    .n_div      (n_div),
    .phase_nxt  (phase_nxt),
    .txc1_nxt   (txc1_nxt),
    .txc2_nxt   (txc2_nxt),
    .win1_nxt   (win1_nxt),
    .win2_nxt   (win2_nxt),
    .strobe_nxt (strobe_nxt)
  );

  // At 1G both nibbles go out in one cycle and TX_CTL carries en / en^er on
  // the two halves. At 10/100 the same nibble is sent on both halves and
  // TX_CTL switches between en and en^er inside the nibble window.
  always_comb begin
    nib_nxt  = (phase_nxt == PHASE_HI) ? held_byte_nxt[7:4] : held_byte_nxt[3:0];
    td1_nxt  = held_byte_nxt[3:0];
    td2_nxt  = held_byte_nxt[7:4];
    ctl1_nxt = held_en_nxt;
    ctl2_nxt = held_en_nxt ^ held_er_nxt;
    if (!gig_nxt) begin
      td1_nxt  = nib_nxt;
      td2_nxt  = nib_nxt;
      ctl1_nxt = win1_nxt ? held_en_nxt : (held_en_nxt ^ held_er_nxt);
      ctl2_nxt = win2_nxt ? held_en_nxt : (held_en_nxt ^ held_er_nxt);
    end
  end

  // Output stage: everything leaving the block comes from these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gmii_tx_clk_en <= 1'b1;
      bus.txc_d1         <= 1'b1;
      bus.txc_d2         <= 1'b0;
      bus.txd_d1         <= '0;
      bus.txd_d2         <= '0;
      bus.tx_ctl_d1      <= 1'b0;
      bus.tx_ctl_d2      <= 1'b0;
      speed_active       <= SPEED_1G;
      held_byte_p0       <= '0;
      held_en_p0         <= 1'b0;
      held_er_p0         <= 1'b0;
    end else begin
      bus.gmii_tx_clk_en <= strobe_nxt;
      bus.txc_d1         <= txc1_nxt;
      bus.txc_d2         <= txc2_nxt;
      bus.txd_d1         <= td1_nxt;
      bus.txd_d2         <= td2_nxt;
      bus.tx_ctl_d1      <= ctl1_nxt;
      bus.tx_ctl_d2      <= ctl2_nxt;
      speed_active       <= speed_nxt;
      held_byte_p0       <= held_byte_nxt;
      held_en_p0         <= held_en_nxt;
      held_er_p0         <= held_er_nxt;
    end
  end

`ifdef RGMII_TX_ER_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // One count per accepted byte flagged as an error inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_er_count <= '0;
    end else if (boundary && bus.gmii_tx_en && bus.gmii_tx_er) begin
      tx_er_count <= sat_inc16(tx_er_count);
    end
  end
`endif

endmodule
